// File: rtl/ramb_fifo_pkg.sv
// Shared sizes and types for the iCE40 block-RAM FIFO controller.
package ramb_fifo_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 16;
  localparam int RAM_DEPTH = 256;
  localparam int BUF_DEPTH = 2;
  localparam int COUNT_W   = 9;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [DATA_W-1:0]  data_t;
  typedef logic [COUNT_W-1:0] count_t;

endpackage

// File: rtl/ramb_fifo_mem.sv
// 256x16 storage: one SB_RAM40_4K (read/write mode 0) when SYNTHESIS is defined,
// an equivalent registered-read array otherwise.
module ramb_fifo_mem
  import ramb_fifo_pkg::*;
(
  input  logic  clk,
  input  logic  we,
  input  addr_t waddr,
  input  data_t wdata,
  input  logic  re,
  input  addr_t raddr,
  output data_t rdata
);

`ifdef SYNTHESIS
  logic [10:0] waddr_pad;
  logic [10:0] raddr_pad;
  logic [15:0] mask;

  assign waddr_pad = {3'b000, waddr};
  assign raddr_pad = {3'b000, raddr};
  assign mask      = 16'h0000;

  SB_RAM40_4K #(
    .READ_MODE (0),
    .WRITE_MODE(0)
  ) ram_i (
    .RDATA(rdata),
    .RADDR(raddr_pad),
    .RCLK (clk),
    .RCLKE(1'b1),
    .RE   (re),
    .WADDR(waddr_pad),
    .WCLK (clk),
    .WCLKE(1'b1),
    .WE   (we),
    .WDATA(wdata),
    .MASK (mask)
  );
`else
  data_t mem [RAM_DEPTH];

  // RAM contents are deliberately never reset, matching the block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
`endif

endmodule

// File: rtl/ramb_fifo_ctrl.sv
// 256x16 block-RAM FIFO with a 2-entry first-word-fall-through output buffer.
// Define RAMB_FIFO_ALMOST_EN to build the almost-full/almost-empty flags.
module ramb_fifo_ctrl
  import ramb_fifo_pkg::*;
#(
  parameter int ALMOST_FULL_LVL  = 240,
  parameter int ALMOST_EMPTY_LVL = 16
) (
  input  logic         CLKIN,
  input  logic         RESETN,
  input  logic [15:0]  I_DATA,
  input  logic         I_VALID,
  output logic         I_READY,
  output logic [15:0]  O_DATA,
  output logic         O_VALID,
  input  logic         O_READY,
  output logic [8:0]   COUNT,
  output logic         O_ALMOST_FULL,
  output logic         O_ALMOST_EMPTY
);

  addr_t       wptr;
  addr_t       rptr;
  count_t      ram_cnt;
  count_t      ram_cnt_n;
  count_t      count_n;
  count_t      count_q;
  logic [1:0]  buf_cnt;
  logic [1:0]  buf_cnt_n;
  logic [1:0]  occ;
  logic [1:0]  wr_idx;
  logic        pend;
  logic        i_ready_q;
  logic        push;
  logic        pop;
  logic        iss;
  data_t       buf_head;
  data_t       buf_tail;
  data_t       rdata;

  assign push    = I_VALID && i_ready_q;
  assign O_VALID = (buf_cnt != 2'd0);
  assign O_DATA  = buf_head;
  assign pop     = O_VALID && O_READY;
  assign I_READY = i_ready_q;
  assign COUNT   = count_q;

  // Only issue a read when the buffer is guaranteed a free slot for the returning word.
  assign occ    = buf_cnt + {1'b0, pend} - {1'b0, pop};
  assign iss    = (ram_cnt != '0) && (occ < 2'd2);
  assign wr_idx = buf_cnt - {1'b0, pop};

  always_comb begin
    ram_cnt_n = ram_cnt;
    if (push && !iss)      ram_cnt_n = ram_cnt + COUNT_W'(1);
    else if (!push && iss) ram_cnt_n = ram_cnt - COUNT_W'(1);

    buf_cnt_n = buf_cnt;
    if (pend && !pop)      buf_cnt_n = buf_cnt + 2'd1;
    else if (!pend && pop) buf_cnt_n = buf_cnt - 2'd1;

    count_n = ram_cnt_n + COUNT_W'(buf_cnt_n) + COUNT_W'(iss);
  end

  ramb_fifo_mem mem_i (
    .clk  (CLKIN),
    .we   (push),
    .waddr(wptr),
    .wdata(I_DATA),
    .re   (iss),
    .raddr(rptr),
    .rdata(rdata)
  );

  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      wptr      <= '0;
      rptr      <= '0;
      ram_cnt   <= '0;
      buf_cnt   <= '0;
      pend      <= 1'b0;
      i_ready_q <= 1'b0;
      count_q   <= '0;
      buf_head  <= '0;
      buf_tail  <= '0;
    end else begin
      if (push) wptr <= wptr + ADDR_W'(1);
      if (iss)  rptr <= rptr + ADDR_W'(1);
      ram_cnt   <= ram_cnt_n;
      buf_cnt   <= buf_cnt_n;
      pend      <= iss;
      i_ready_q <= (ram_cnt_n != COUNT_W'(RAM_DEPTH));
      count_q   <= count_n;
      if (pop) buf_head <= buf_tail;
      // A returning word lands in the first free slot once this cycle's pop is applied.
      if (pend) begin
        if (wr_idx == 2'd0) buf_head <= rdata;
        else                buf_tail <= rdata;
      end
    end
  end

`ifdef RAMB_FIFO_ALMOST_EN
  logic almost_full_q;
  logic almost_empty_q;

  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= (count_n >= COUNT_W'(ALMOST_FULL_LVL));
      almost_empty_q <= (count_n <= COUNT_W'(ALMOST_EMPTY_LVL));
    end
  end

  assign O_ALMOST_FULL  = almost_full_q;
  assign O_ALMOST_EMPTY = almost_empty_q;
`else
  assign O_ALMOST_FULL  = 1'b0;
  assign O_ALMOST_EMPTY = 1'b0;
`endif

endmodule

// File: tb/tb_ramb_fifo_ctrl.sv
// Bench for ramb_fifo_ctrl: queue-based FIFO model checked every cycle plus directed literal checks.
module tb_ramb_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] i_data;
  logic        i_valid;
  logic        i_ready;
  logic [15:0] o_data;
  logic        o_valid;
  logic        o_ready;
  logic [8:0]  count;
  logic        almost_full;
  logic        almost_empty;

  int          checks = 0;
  int          failures = 0;
  int          since_rst = 0;
  logic [15:0] model_q[$];

`ifdef RAMB_FIFO_ALMOST_EN
  localparam bit ALMOST_ON = 1'b1;
`else
  localparam bit ALMOST_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  ramb_fifo_ctrl #(
    .ALMOST_FULL_LVL (240),
    .ALMOST_EMPTY_LVL(16)
  ) dut (
    .CLKIN         (clk),
    .RESETN        (rst_n),
    .I_DATA        (i_data),
    .I_VALID       (i_valid),
    .I_READY       (i_ready),
    .O_DATA        (o_data),
    .O_VALID       (o_valid),
    .O_READY       (o_ready),
    .COUNT         (count),
    .O_ALMOST_FULL (almost_full),
    .O_ALMOST_EMPTY(almost_empty)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Model: contents are exactly the accepted words not yet consumed; handshakes are applied
  // at the negedge before the edge that samples them.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_q.delete();
      since_rst = 0;
      check_output("rst_count", 32'(count), 32'd0);
      check_output("rst_o_valid", 32'(o_valid), 32'd0);
      check_output("rst_o_data", 32'(o_data), 32'd0);
      check_output("rst_i_ready", 32'(i_ready), 32'd0);
      check_output("rst_almost_full", 32'(almost_full), 32'd0);
      check_output("rst_almost_empty", 32'(almost_empty), 32'(ALMOST_ON));
    end else begin
      check_output("model_count", 32'(count), 32'(model_q.size()));
      if (o_valid) begin
        if (model_q.size() == 0) check_output("model_valid_when_empty", 32'(o_valid), 32'd0);
        else                     check_output("model_o_data", 32'(o_data), 32'(model_q[0]));
      end
      if (since_rst > 0) begin
        if (model_q.size() <= 255) check_output("model_i_ready_open", 32'(i_ready), 32'd1);
        if (model_q.size() == 258) check_output("model_i_ready_full", 32'(i_ready), 32'd0);
      end
      check_output("model_almost_full", 32'(almost_full),
                   32'(ALMOST_ON && (model_q.size() >= 240)));
      check_output("model_almost_empty", 32'(almost_empty),
                   32'(ALMOST_ON && (model_q.size() <= 16)));
      if (o_valid && o_ready && model_q.size() > 0) void'(model_q.pop_front());
      if (i_valid && i_ready) model_q.push_back(i_data);
      since_rst++;
    end
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_output("reset_now_o_valid", 32'(o_valid), 32'd0);
    check_output("reset_now_count", 32'(count), 32'd0);
    check_output("reset_now_o_data", 32'(o_data), 32'd0);
    check_output("reset_now_i_ready", 32'(i_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic push_words(input int n, input logic [15:0] base);
    int pushed = 0;
    int guard = 0;
    @(posedge clk); #1;
    i_valid = 1'b1;
    i_data  = base;
    while (pushed < n) begin
      @(negedge clk);
      if (i_ready) pushed++;
      @(posedge clk); #1;
      i_data = base + 16'(pushed);
      guard++;
      if (guard > n + 20) begin
        check_output("push_timeout", 32'(pushed), 32'(n));
        break;
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic pop_words(input int n);
    int popped = 0;
    int guard = 0;
    @(posedge clk); #1;
    o_ready = 1'b1;
    while (popped < n) begin
      @(negedge clk);
      if (o_valid) popped++;
      @(posedge clk); #1;
      guard++;
      if (guard > n + 20) begin
        check_output("pop_timeout", 32'(popped), 32'(n));
        break;
      end
    end
    o_ready = 1'b0;
  endtask

  task automatic wait_for_valid(input string name);
    int guard = 0;
    @(negedge clk);
    while (!o_valid && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check_output(name, 32'(o_valid), 32'd1);
  endtask

  initial begin
    rst_n   = 1'b0;
    i_data  = 16'h0000;
    i_valid = 1'b0;
    o_ready = 1'b0;
    apply_reset();

    // Latency from empty and stable head while the consumer stalls.
    push_words(1, 16'h0001);
    @(negedge clk); check_output("lat_edge1", 32'(o_valid), 32'd0);
    @(negedge clk); check_output("lat_edge2", 32'(o_valid), 32'd0);
    @(negedge clk); check_output("lat_edge3", 32'(o_valid), 32'd1);
    check_output("lat_head", 32'(o_data), 32'h0001);
    push_words(3, 16'h0002);
    repeat (4) @(negedge clk);
    check_output("four_count", 32'(count), 32'd4);
    check_output("four_head", 32'(o_data), 32'h0001);
    repeat (3) @(negedge clk);
    check_output("four_head_held", 32'(o_data), 32'h0001);
    pop_words(4);

    // Fill to 258 total, push into a full FIFO, then drain in order.
    apply_reset();
    push_words(258, 16'h0100);
    @(negedge clk);
    check_output("full_count", 32'(count), 32'd258);
    check_output("full_i_ready", 32'(i_ready), 32'd0);
    @(posedge clk); #1;
    i_valid = 1'b1;
    i_data  = 16'hDEAD;
    repeat (3) @(posedge clk);
    #1;
    i_valid = 1'b0;
    @(negedge clk);
    check_output("full_push_ignored", 32'(count), 32'd258);
    check_output("full_head", 32'(o_data), 32'h0100);
    pop_words(258);
    @(negedge clk);
    check_output("drained_count", 32'(count), 32'd0);

    // Back-to-back delivery with no bubbles.
    apply_reset();
    push_words(10, 16'h0A00);
    repeat (4) @(negedge clk);
    begin
      int run = 0;
      bit ended = 1'b0;
      @(posedge clk); #1;
      o_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (o_valid && !ended) run++;
        else ended = 1'b1;
      end
      @(posedge clk); #1;
      o_ready = 1'b0;
      check_output("stream_run", 32'(run), 32'd10);
    end

    // Steady push+pop at depth 5 for 512 cycles; pointers wrap.
    apply_reset();
    push_words(5, 16'h2000);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    o_ready = 1'b1;
    i_valid = 1'b1;
    i_data  = 16'h3000;
    for (int i = 0; i < 512; i++) begin
      @(posedge clk); #1;
      i_data = 16'h3001 + 16'(i);
    end
    i_valid = 1'b0;
    o_ready = 1'b0;
    @(negedge clk);
    check_output("steady_count", 32'(count), 32'd5);
    pop_words(4);
    @(negedge clk);
    check_output("steady_last_word", 32'(o_data), 32'h31FF);
    pop_words(1);

    // Reset with a read in flight, then the first word out must be the new one.
    apply_reset();
    push_words(1, 16'h1234);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_output("midrst_o_valid", 32'(o_valid), 32'd0);
    check_output("midrst_o_data", 32'(o_data), 32'd0);
    check_output("midrst_count", 32'(count), 32'd0);
    check_output("midrst_i_ready", 32'(i_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_output("midrst_i_ready_before_edge", 32'(i_ready), 32'd0);
    push_words(1, 16'hBEEF);
    wait_for_valid("midrst_valid_timeout");
    check_output("midrst_first_word", 32'(o_data), 32'hBEEF);
    check_output("midrst_count_one", 32'(count), 32'd1);
    pop_words(1);

    // Almost-full and almost-empty thresholds.
    apply_reset();
    push_words(239, 16'h4000);
    repeat (4) @(negedge clk);
    check_output("af_239_count", 32'(count), 32'd239);
    check_output("af_239_flag", 32'(almost_full), 32'd0);
    push_words(1, 16'h40EF);
    @(negedge clk);
    check_output("af_240_count", 32'(count), 32'd240);
    check_output("af_240_flag", 32'(almost_full), 32'(ALMOST_ON));
    pop_words(223);
    @(negedge clk);
    check_output("ae_17_count", 32'(count), 32'd17);
    check_output("ae_17_flag", 32'(almost_empty), 32'd0);
    pop_words(1);
    @(negedge clk);
    check_output("ae_16_count", 32'(count), 32'd16);
    check_output("ae_16_flag", 32'(almost_empty), 32'(ALMOST_ON));
    pop_words(16);
    @(negedge clk);
    check_output("final_count", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    check_output("global_timeout", 32'd0, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
